// File: rtl/axil_bridge_pkg.sv
// Shared types for the AXI-Lite to simple-bus bridge.
// FSM states, response codes and arbitration grant encoding.
package axil_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUS_WR,
        ST_BUS_RD,
        ST_WR_RESP,
        ST_RD_RESP
    } state_t;

    typedef enum logic {
        GNT_READ,
        GNT_WRITE
    } grant_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_hold_reg.sv
// One-entry valid/ready capture register.
// Loads on handshake, empties on clr_i; ready is low while in reset.
module axil_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    input  logic             clr_i,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);

    logic             full_q;
    logic [WIDTH-1:0] data_q;

    assign ready_o = rst_ni & ~full_q;
    assign full_o  = full_q;
    assign data_o  = data_q;

    // Capture on handshake, release when the owning response completes
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (clr_i) begin
            full_q <= 1'b0;
        end else if (valid_i && ready_o) begin
            full_q <= 1'b1;
            data_q <= data_i;
        end
    end

endmodule

// File: rtl/axil_to_simple_bus_bridge.sv
// AXI-Lite responder driving the single-outstanding simple bus.
// Buffers AW/W/AR independently, arbitrates, and times out slow slaves.
module axil_to_simple_bus_bridge
    import axil_bridge_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES     = 256
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]                    s_axi_awprot,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [31:0]                   s_axi_wdata,
    input  logic [3:0]                    s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]                    s_axi_arprot,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [31:0]                   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic                          stb_o,
    output logic [C_S_AXI_ADDR_WIDTH-3:0] adr_o,
    output logic [3:0]                    byte_sel_o,
    output logic                          we_o,
    output logic [31:0]                   dat_o,
    input  logic [31:0]                   dat_i,
    input  logic                          ack_i
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    state_t        state;
    grant_t        last_grant;
    logic [CW-1:0] to_cnt;

    logic          aw_full;
    logic          w_full;
    logic          ar_full;
    logic [AW-1:0] aw_addr;
    logic [AW-1:0] ar_addr;
    logic [31:0]   w_data;
    logic [3:0]    w_strb;
    logic          wr_clr;
    logic          rd_clr;
    logic          wr_rdy;
    logic          rd_rdy;
    logic          timed_out;
    logic          unused_ok;

    assign wr_clr    = s_axi_bvalid & s_axi_bready;
    assign rd_clr    = s_axi_rvalid & s_axi_rready;
    assign wr_rdy    = aw_full & w_full;
    assign rd_rdy    = ar_full;
    assign timed_out = TO_EN && (to_cnt == TO_LAST);
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot,
                         aw_addr[1:0], ar_addr[1:0]};

    axil_hold_reg #(.WIDTH(AW)) u_aw (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (s_axi_awvalid),
        .ready_o (s_axi_awready),
        .data_i  (s_axi_awaddr),
        .clr_i   (wr_clr),
        .full_o  (aw_full),
        .data_o  (aw_addr)
    );

    axil_hold_reg #(.WIDTH(36)) u_w (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (s_axi_wvalid),
        .ready_o (s_axi_wready),
        .data_i  ({s_axi_wstrb, s_axi_wdata}),
        .clr_i   (wr_clr),
        .full_o  (w_full),
        .data_o  ({w_strb, w_data})
    );

    axil_hold_reg #(.WIDTH(AW)) u_ar (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (s_axi_arvalid),
        .ready_o (s_axi_arready),
        .data_i  (s_axi_araddr),
        .clr_i   (rd_clr),
        .full_o  (ar_full),
        .data_o  (ar_addr)
    );

    // Transaction FSM: arbitrate, run one bus cycle, hold the response
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= ST_IDLE;
            last_grant   <= GNT_READ;
            to_cnt       <= '0;
            stb_o        <= 1'b0;
            we_o         <= 1'b0;
            adr_o        <= '0;
            byte_sel_o   <= '0;
            dat_o        <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
            s_axi_rvalid <= 1'b0;
            s_axi_rresp  <= RESP_OKAY;
            s_axi_rdata  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (wr_rdy && (!rd_rdy || last_grant == GNT_READ)) begin
                        if (rd_rdy) last_grant <= GNT_WRITE;
                        state      <= ST_BUS_WR;
                        to_cnt     <= '0;
                        stb_o      <= 1'b1;
                        we_o       <= 1'b1;
                        adr_o      <= aw_addr[AW-1:2];
                        byte_sel_o <= w_strb;
                        dat_o      <= w_data;
                    end else if (rd_rdy) begin
                        if (wr_rdy) last_grant <= GNT_READ;
                        state      <= ST_BUS_RD;
                        to_cnt     <= '0;
                        stb_o      <= 1'b1;
                        we_o       <= 1'b0;
                        adr_o      <= ar_addr[AW-1:2];
                        byte_sel_o <= 4'hF;
                        dat_o      <= w_data;
                    end
                end
                ST_BUS_WR, ST_BUS_RD: begin
                    if (ack_i || timed_out) begin
                        stb_o <= 1'b0;
                        we_o  <= 1'b0;
                        if (state == ST_BUS_WR) begin
                            state        <= ST_WR_RESP;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= ack_i ? RESP_OKAY : RESP_SLVERR;
                        end else begin
                            state        <= ST_RD_RESP;
                            s_axi_rvalid <= 1'b1;
                            s_axi_rresp  <= ack_i ? RESP_OKAY : RESP_SLVERR;
                            s_axi_rdata  <= ack_i ? dat_i : 32'h0;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_WR_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                ST_RD_RESP: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
